control_mult_fp: RTL and testbench

Sequencing controller for the floating-point multiplier datapath. It accepts a start request and drives the datapath control strobes in order: operand load, then sign/exponent capture, then an iterative shift-add mantissa multiply, then single-step normalization, then result load. It sits between the bus/testbench request logic and the multiplier datapath (sign XOR, exponent adder, mantissa multiplier, normalizer). It contains no arithmetic of its own, only the FSM, the iteration counter and the zero-operand bypass.

---
 rtl/control_mult_fp.sv | 102 ++++++++++
 tb/tb_control_mult_fp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_mult_fp.sv
// Sequencing controller for the floating-point multiplier datapath.
// Walks the datapath through operand load, sign/exponent capture, ANCHO_MANT
// shift-add steps, one normalization step and result load. A zero operand
// detected at sign/exponent capture skips the multiply and forces a zero result.
//
// Handshake: Inicio is a level request that is only looked at while idle; a
// request seen outside IDLE is dropped, not queued. Listo is a single-cycle
// completion pulse, coincident with Carga_Res, and Ocupado covers every cycle
// from CARGA through FIN inclusive.
module control_mult_fp #(
  parameter int ANCHO_MANT = 24,
  localparam int CW = (ANCHO_MANT > 1) ? $clog2(ANCHO_MANT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Inicio,
  input  logic          Es_Cero,
  input  logic          Desborde_Norm,
  output logic          Carga_Op,
  output logic          Carga_SE,
  output logic          Paso_Mult,
  output logic          Despl_Norm,
  output logic          Forzar_Cero,
  output logic          Carga_Res,
  output logic          Ocupado,
  output logic          Listo,
  output logic [CW-1:0] Cuenta,
  output logic [2:0]    estado
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CARGA     = 3'd1,
    SIGNO_EXP = 3'd2,
    MULT      = 3'd3,
    NORM      = 3'd4,
    FIN       = 3'd5
  } estado_t;

  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO_MANT - 1);

  estado_t         state;
  logic [CW-1:0]   cuenta;
  logic            cero;

  // State register, iteration counter and latched zero-operand flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cuenta <= '0;
      cero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Inicio) state <= CARGA;
        end
        CARGA: begin
          state <= SIGNO_EXP;
        end
        SIGNO_EXP: begin
          // Zero flag is captured here only; it steers both the bypass and FIN.
          cero   <= Es_Cero;
          cuenta <= '0;
          state  <= Es_Cero ? FIN : MULT;
        end
        MULT: begin
          if (cuenta == ULTIMO) begin
            cuenta <= '0;
            state  <= NORM;
          end else begin
            cuenta <= cuenta + CW'(1);
          end
        end
        NORM: begin
          state <= FIN;
        end
        FIN: begin
          cero  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          cuenta <= '0;
          cero   <= 1'b0;
        end
      endcase
    end
  end

  // Strobes decoded from the registered state only (plus zero flag / overflow).
  assign Carga_Op    = (state == CARGA);
  assign Carga_SE    = (state == SIGNO_EXP);
  assign Paso_Mult   = (state == MULT);
  assign Despl_Norm  = (state == NORM) && Desborde_Norm;
  assign Forzar_Cero = (state == FIN) && cero;
  assign Carga_Res   = (state == FIN);
  assign Listo       = (state == FIN);
  assign Ocupado     = (state != IDLE);
  assign Cuenta      = cuenta;
  assign estado      = state;

endmodule

// File: tb/tb_control_mult_fp.sv
// Bench for control_mult_fp: a behavioural FP datapath around the default
// instance, plus a 4-bit-mantissa instance for the parameter sweep.
`timescale 1ns/1ps
module tb_control_mult_fp;

  localparam int A = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // ---------------- DUT (ANCHO_MANT = 24) ----------------
  logic        Inicio = 1'b0;
  logic        Es_Cero, Desborde_Norm;
  logic        Carga_Op, Carga_SE, Paso_Mult, Despl_Norm, Forzar_Cero;
  logic        Carga_Res, Ocupado, Listo;
  logic [4:0]  Cuenta;
  logic [2:0]  estado;

  control_mult_fp #(.ANCHO_MANT(A)) dut (
    .clk(clk), .rst(rst), .Inicio(Inicio), .Es_Cero(Es_Cero),
    .Desborde_Norm(Desborde_Norm), .Carga_Op(Carga_Op), .Carga_SE(Carga_SE),
    .Paso_Mult(Paso_Mult), .Despl_Norm(Despl_Norm), .Forzar_Cero(Forzar_Cero),
    .Carga_Res(Carga_Res), .Ocupado(Ocupado), .Listo(Listo), .Cuenta(Cuenta),
    .estado(estado)
  );

  // ---------------- DUT (ANCHO_MANT = 4) ----------------
  logic        Inicio_4 = 1'b0;
  logic        Es_Cero_4 = 1'b0, Desborde_4 = 1'b0;
  logic        Carga_Op_4, Carga_SE_4, Paso_Mult_4, Despl_Norm_4, Forzar_Cero_4;
  logic        Carga_Res_4, Ocupado_4, Listo_4;
  logic [1:0]  Cuenta_4;
  logic [2:0]  estado_4;

  control_mult_fp #(.ANCHO_MANT(4)) dut4 (
    .clk(clk), .rst(rst), .Inicio(Inicio_4), .Es_Cero(Es_Cero_4),
    .Desborde_Norm(Desborde_4), .Carga_Op(Carga_Op_4), .Carga_SE(Carga_SE_4),
    .Paso_Mult(Paso_Mult_4), .Despl_Norm(Despl_Norm_4), .Forzar_Cero(Forzar_Cero_4),
    .Carga_Res(Carga_Res_4), .Ocupado(Ocupado_4), .Listo(Listo_4), .Cuenta(Cuenta_4),
    .estado(estado_4)
  );

  // ---------------- behavioural datapath ----------------
  logic [31:0] in_a = 32'h0, in_b = 32'h0;
  logic [31:0] a_r, b_r, res_r;
  logic        sgn;
  logic [9:0]  exp_r;
  logic [47:0] prod;
  logic [23:0] mcand, mplier;

  assign mcand         = {1'b1, a_r[22:0]};
  assign mplier        = {1'b1, b_r[22:0]};
  assign Es_Cero       = (a_r[30:0] == 31'h0) || (b_r[30:0] == 31'h0);
  assign Desborde_Norm = prod[47];

  always @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; prod <= '0; sgn <= 1'b0; exp_r <= '0;
    end else begin
      if (Carga_Op) begin
        a_r <= in_a; b_r <= in_b; prod <= '0;
      end
      if (Carga_SE) begin
        sgn   <= a_r[31] ^ b_r[31];
        exp_r <= {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - 10'd127;
      end
      if (Paso_Mult && mplier[Cuenta]) prod <= prod + ({24'h0, mcand} << Cuenta);
      if (Despl_Norm) begin
        prod  <= prod >> 1;
        exp_r <= exp_r + 10'd1;
      end
      if (Carga_Res) res_r <= Forzar_Cero ? {sgn, 31'h0} : {sgn, exp_r[7:0], prod[45:23]};
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  lat;    // cycles from CARGA (=1) to Listo
    logic [7:0]  pasos;  // Paso_Mult cycles
    logic        despl;  // Despl_Norm seen
    logic        fz;     // Forzar_Cero at Listo
    logic [7:0]  gap;    // cycles since previous Listo, 0 = don't care
    logic [31:0] res;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp4_q[$];   // {lat, pasos} for the 4-bit instance
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int lat, input int pasos, input bit despl,
                              input bit fz, input int gap, input logic [31:0] res);
    exp_t e;
    e.lat = 8'(lat); e.pasos = 8'(pasos); e.despl = despl; e.fz = fz;
    e.gap = 8'(gap); e.res = res;
    return e;
  endfunction

  // Monitor for the default instance.
  int   lat = 0, pasos = 0, since_listo = 1000;
  bit   in_op = 0, despl = 0, chk_res = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      in_op = 0; chk_res = 0;
    end else begin
      if (chk_res) begin
        check("result", {32'h0, res_r}, {32'h0, cur.res});
        chk_res = 0;
      end
      if (Carga_Op) begin
        check("carga_op_while_busy", {63'h0, in_op}, 64'h0);
        in_op = 1; lat = 0; pasos = 0; despl = 0;
      end
      if (in_op) lat++;
      if (Paso_Mult) pasos++;
      if (Despl_Norm) despl = 1;
      since_listo++;
      check("ocupado", {63'h0, Ocupado}, {63'h0, in_op});
      check("carga_res_vs_listo", {63'h0, Carga_Res}, {63'h0, Listo});
      check("forzar_outside_fin", {63'h0, Forzar_Cero & ~Listo}, 64'h0);
      if (Listo) begin
        if (exp_q.size() == 0) begin
          check("unexpected_listo", 64'h1, 64'h0);
        end else begin
          cur = exp_q.pop_front();
          check("latency", 64'(lat), {56'h0, cur.lat});
          check("paso_count", 64'(pasos), {56'h0, cur.pasos});
          check("despl_norm", {63'h0, despl}, {63'h0, cur.despl});
          check("forzar_cero", {63'h0, Forzar_Cero}, {63'h0, cur.fz});
          if (cur.gap != 0) check("listo_period", 64'(since_listo), {56'h0, cur.gap});
          chk_res = 1;
        end
        since_listo = 0; in_op = 0;
      end
    end
  end

  // Monitor for the 4-bit instance.
  int   lat4 = 0, p4 = 0;
  bit   in4 = 0, prev_paso4 = 0;
  logic [1:0]  prev_cnt4 = 2'd0;
  logic [15:0] cur4;

  always @(negedge clk) begin
    if (rst) begin
      in4 = 0; prev_paso4 = 0;
    end else begin
      if (Carga_Op_4) begin in4 = 1; lat4 = 0; p4 = 0; end
      if (in4) lat4++;
      if (Paso_Mult_4) p4++;
      if (prev_paso4 && !Paso_Mult_4 && in4) begin
        check("w4_cuenta_last", {62'h0, prev_cnt4}, 64'd3);
        check("w4_cuenta_wrap", {62'h0, Cuenta_4}, 64'd0);
      end
      prev_paso4 = Paso_Mult_4;
      prev_cnt4  = Cuenta_4;
      if (Listo_4) begin
        if (exp4_q.size() == 0) begin
          check("w4_unexpected_listo", 64'h1, 64'h0);
        end else begin
          cur4 = exp4_q.pop_front();
          check("w4_latency", 64'(lat4), {56'h0, cur4[15:8]});
          check("w4_paso_count", 64'(p4), {56'h0, cur4[7:0]});
        end
        in4 = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit push);
    @(negedge clk);
    in_a = a; in_b = b; Inicio = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    Inicio = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("completion_timeout", 64'(exp_q.size() + exp4_q.size()), 64'h0);
    exp_q.delete();
    exp4_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {53'h0, Carga_Op, Carga_SE, Paso_Mult, Despl_Norm, Forzar_Cero,
                 Carga_Res, Ocupado, Listo, Cuenta, 1'b0}, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    check("reset_state_w4", {55'h0, Ocupado_4, Listo_4, Paso_Mult_4, Cuenta_4, 3'b0}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Normal operands: 1.5 x 2.0 = 3.0 (no overflow), 1.5 x 1.5 = 2.25 (overflow), 5.0 x 2.0 = 10.0
    issue(32'h3FC00000, 32'h40000000, mk(A + 4, A, 0, 0, 0, 32'h40400000), 1);
    wait_done();
    issue(32'h3FC00000, 32'h3FC00000, mk(A + 4, A, 1, 0, 0, 32'h40100000), 1);
    wait_done();
    issue(32'h40A00000, 32'h40000000, mk(A + 4, A, 0, 0, 0, 32'h41200000), 1);
    wait_done();

    // Zero-operand bypass, with sign preserved
    issue(32'h00000000, 32'h40A00000, mk(3, 0, 0, 1, 0, 32'h00000000), 1);
    wait_done();
    issue(32'h80000000, 32'h40A00000, mk(3, 0, 0, 1, 0, 32'h80000000), 1);
    wait_done();
    issue(32'h40A00000, 32'h00000000, mk(3, 0, 0, 1, 0, 32'h00000000), 1);
    wait_done();

    // Inicio held for 100 sampling edges: starts at edges 1, 30, 59, 88
    @(negedge clk);
    in_a = 32'h3FC00000; in_b = 32'h40000000; Inicio = 1'b1;
    exp_q.push_back(mk(A + 4, A, 0, 0, 0, 32'h40400000));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(A + 4, A, 0, 0, A + 5, 32'h40400000));
    repeat (100) @(negedge clk);
    Inicio = 1'b0;
    wait_done();

    // Inicio pulsed mid-multiply is ignored
    issue(32'h3FC00000, 32'h3FC00000, mk(A + 4, A, 1, 0, 0, 32'h40100000), 1);
    repeat (10) @(negedge clk);
    Inicio = 1'b1;
    @(negedge clk);
    Inicio = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    check("no_queued_start", {63'h0, Ocupado}, 64'h0);

    // Reset during MULT at Cuenta = 10: no Listo, then a full operation runs
    issue(32'h3FC00000, 32'h40000000, mk(0, 0, 0, 0, 0, 32'h0), 0);
    begin
      int t = 0;
      while (!(Paso_Mult && Cuenta == 5'd10) && t < 60) begin
        @(negedge clk);
        t++;
      end
      check("reach_cuenta_10", {63'h0, Paso_Mult && Cuenta == 5'd10}, 64'h1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_mult");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("idle_after_reset");
    issue(32'h3FC00000, 32'h40000000, mk(A + 4, A, 0, 0, 0, 32'h40400000), 1);
    wait_done();

    // ANCHO_MANT = 4 instance
    @(negedge clk);
    Inicio_4 = 1'b1;
    exp4_q.push_back({8'd8, 8'd4});
    @(negedge clk);
    Inicio_4 = 1'b0;
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
